// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM native-port arbiter.
// State encoding and the read-data fill pattern used on timeout.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_t;

  localparam logic RDATA_TIMEOUT_FILL = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after last_grant.
// Scans last+1, last+2, ... wrapping modulo NUM_REQ.
module rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [IW-1:0]      o_idx,
  output logic               o_valid
);

  int w_pos;

  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_pos = (int'(i_last) + k) % NUM_REQ;
      if (!o_valid && i_req[w_pos]) begin
        o_valid = 1'b1;
        o_idx   = IW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin sharing of the SDRAM controller native command port.
// One transaction in flight; grant held until completion or timeout.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            i_sysclk,
  input  logic                            i_rst,
  input  logic [NUM_REQ-1:0]              i_req,
  input  logic [NUM_REQ-1:0]              i_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] i_wstrb,
  output logic [NUM_REQ-1:0]              o_ack,
  output logic [NUM_REQ-1:0]              o_rvalid,
  output logic [DATA_WIDTH-1:0]           o_rdata,
  output logic                            o_mem_req,
  output logic                            o_mem_we,
  output logic [ADDR_WIDTH-1:0]           o_mem_addr,
  output logic [DATA_WIDTH-1:0]           o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0]         o_mem_wstrb,
  input  logic                            i_mem_ack,
  input  logic                            i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]           i_mem_rdata,
  output logic                            o_timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_t            r_state, w_state;
  logic [IW-1:0]         r_last, w_last;
  logic [IW-1:0]         r_g, w_g;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic                  r_mem_req, w_mem_req;
  logic                  r_mem_we, w_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata;
  logic [SW-1:0]         r_mem_wstrb, w_mem_wstrb;
  logic [NUM_REQ-1:0]    r_ack, w_ack;
  logic [NUM_REQ-1:0]    r_rvalid, w_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata;
  logic                  r_timeout, w_timeout;

  logic [IW-1:0]         w_pick;
  logic                  w_pick_valid;
  logic [NUM_REQ-1:0]    w_g_onehot;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_rr (
    .i_req  (i_req),
    .i_last (r_last),
    .o_idx  (w_pick),
    .o_valid(w_pick_valid)
  );

  assign w_g_onehot = NUM_REQ'(1) << r_g;

  always_comb begin
    w_state     = r_state;
    w_last      = r_last;
    w_g         = r_g;
    w_cnt       = r_cnt;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_mem_wstrb = r_mem_wstrb;
    w_ack       = '0;
    w_rvalid    = '0;
    w_rdata     = r_rdata;
    w_timeout   = r_timeout;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_g         = w_pick;
          w_mem_we    = i_we[w_pick];
          w_mem_addr  = i_addr[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
          w_mem_wdata = i_wdata[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
          w_mem_wstrb = i_wstrb[int'(w_pick)*SW +: SW];
          w_mem_req   = 1'b1;
          w_cnt       = '0;
          w_state     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_mem_ack) begin
          w_mem_req = 1'b0;
          if (r_mem_we) begin
            w_ack   = w_g_onehot;
            w_state = ST_DONE;
          end else if (i_mem_rvalid) begin
            w_ack    = w_g_onehot;
            w_rvalid = w_g_onehot;
            w_rdata  = i_mem_rdata;
            w_state  = ST_DONE;
          end else begin
            w_state = ST_WAIT_RD;
          end
        end else if (r_cnt == CNT_LAST) begin
          // Controller never answered: complete anyway so the master unblocks
          w_mem_req = 1'b0;
          w_ack     = w_g_onehot;
          w_timeout = 1'b1;
          if (!r_mem_we) begin
            w_rvalid = w_g_onehot;
            w_rdata  = {DATA_WIDTH{RDATA_TIMEOUT_FILL}};
          end
          w_state = ST_DONE;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      ST_WAIT_RD: begin
        if (i_mem_rvalid) begin
          w_ack    = w_g_onehot;
          w_rvalid = w_g_onehot;
          w_rdata  = i_mem_rdata;
          w_state  = ST_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_ack     = w_g_onehot;
          w_rvalid  = w_g_onehot;
          w_rdata   = {DATA_WIDTH{RDATA_TIMEOUT_FILL}};
          w_timeout = 1'b1;
          w_state   = ST_DONE;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      ST_DONE: begin
        w_last  = r_g;
        w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_last      <= IW'(NUM_REQ - 1);
      r_g         <= '0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_ack       <= '0;
      r_rvalid    <= '0;
      r_rdata     <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_last      <= w_last;
      r_g         <= w_g;
      r_cnt       <= w_cnt;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_wstrb <= w_mem_wstrb;
      r_ack       <= w_ack;
      r_rvalid    <= w_rvalid;
      r_rdata     <= w_rdata;
      r_timeout   <= w_timeout;
    end
  end

  assign o_ack       = r_ack;
  assign o_rvalid    = r_rvalid;
  assign o_rdata     = r_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wstrb = r_mem_wstrb;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: reads, writes, contention,
// timeout and reset abort, with hand-computed expectations.
module tb_sdram_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req, we;
  logic [NR*AW-1:0] addr;
  logic [NR*DW-1:0] wdata;
  logic [NR*SW-1:0] wstrb;
  logic [NR-1:0] ack, rvalid;
  logic [DW-1:0] rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_ack, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          tmo;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .NUM_REQ       (NR),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_sysclk    (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_wstrb     (wstrb),
    .o_ack       (ack),
    .o_rvalid    (rvalid),
    .o_rdata     (rdata),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_wstrb (mem_wstrb),
    .i_mem_ack   (mem_ack),
    .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata (mem_rdata),
    .o_timeout   (tmo)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req        = '0;
    we         = '0;
    addr       = '0;
    wdata      = '0;
    wstrb      = '0;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  logic [AW-1:0] exp_addr [4];
  logic [NR-1:0] exp_ack  [4];
  int            cyc;
  logic          seen;

  initial begin
    idle_inputs();
    do_reset();
    check("rst_mem_req", mem_req, 0);
    check("rst_ack", ack, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_timeout", tmo, 0);
    check("rst_mem_addr", mem_addr, 0);

    // single read, ack after 2 cycles, data 5 cycles later
    req = 2'b01; we = 2'b00; addr[0 +: AW] = 32'h0000_0100;
    tick();
    check("rd_mem_req", mem_req, 1);
    check("rd_mem_addr", mem_addr, 32'h100);
    check("rd_mem_we", mem_we, 0);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("rd_req_drop", mem_req, 0);
    repeat (4) begin
      tick();
      check("rd_wait_noack", ack, 0);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    check("rd_ack", ack, 2'b01);
    check("rd_rvalid", rvalid, 2'b01);
    check("rd_rdata", rdata, 32'hDEAD_BEEF);
    req = 2'b00;
    tick();
    check("rd_ack_pulse", ack, 0);

    // write with byte strobes from req1
    req = 2'b10; we = 2'b10;
    addr[AW +: AW]  = 32'h10;
    wdata[DW +: DW] = 32'h1122_3344;
    wstrb[SW +: SW] = 4'b0010;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("wr_mem_req", mem_req, 1);
      check("wr_mem_we", mem_we, 1);
      check("wr_mem_addr", mem_addr, 32'h10);
      check("wr_mem_wdata", mem_wdata, 32'h1122_3344);
      check("wr_mem_wstrb", mem_wstrb, 4'b0010);
      if (i < 2) tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("wr_ack", ack, 2'b10);
    check("wr_rvalid", rvalid, 2'b00);
    req = 2'b00; we = 2'b00;
    tick();

    // same-cycle ack and rvalid
    req = 2'b01; addr[0 +: AW] = 32'h200;
    tick();
    check("sc_mem_req", mem_req, 1);
    mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0; mem_rvalid = 1'b0;
    check("sc_ack", ack, 2'b01);
    check("sc_rvalid", rvalid, 2'b01);
    check("sc_rdata", rdata, 32'hCAFE_F00D);
    check("sc_mem_req", mem_req, 0);
    req = 2'b00;
    tick();

    // contention from reset: both writes held, grants alternate
    idle_inputs();
    do_reset();
    req = 2'b11; we = 2'b11;
    addr[0 +: AW]  = 32'hA0;
    addr[AW +: AW] = 32'hB0;
    exp_addr = '{32'hA0, 32'hB0, 32'hA0, 32'hB0};
    exp_ack  = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int t = 0; t < 4; t++) begin
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        tick();
        seen = mem_req;
      end
      check("ct_grant_seen", seen, 1);
      check("ct_mem_addr", mem_addr, exp_addr[t]);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("ct_ack", ack, exp_ack[t]);
      if (t == 3) req = 2'b00;
    end
    tick();
    we = 2'b00;

    // timeout on a read that is never acknowledged
    req = 2'b01; addr[0 +: AW] = 32'h300;
    tick();
    check("to_mem_req", mem_req, 1);
    cyc = 0;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      tick();
      if (ack != 0) begin
        seen = 1'b1;
        cyc = c;
      end
    end
    check("to_ack_seen", seen, 1);
    check("to_latency", cyc, 16);
    check("to_ack", ack, 2'b01);
    check("to_rvalid", rvalid, 2'b01);
    check("to_rdata", rdata, 32'hFFFF_FFFF);
    check("to_mem_req_drop", mem_req, 0);
    check("to_flag", tmo, 1);
    req = 2'b00;
    repeat (3) tick();
    check("to_sticky", tmo, 1);

    // reset in WAIT_RD, then a late rvalid must be dropped
    req = 2'b10; addr[AW +: AW] = 32'h400;
    tick();
    check("ra_grant1", mem_addr, 32'h400);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    req = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ra_rst_req", mem_req, 0);
    check("ra_rst_timeout", tmo, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    check("ra_late_ack", ack, 0);
    check("ra_late_rvalid", rvalid, 0);
    req = 2'b11;
    addr[0 +: AW]  = 32'h500;
    addr[AW +: AW] = 32'h600;
    tick();
    check("ra_first_grant", mem_addr, 32'h500);
    mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55AA_55AA;
    tick();
    mem_ack = 1'b0; mem_rvalid = 1'b0;
    check("ra_ack", ack, 2'b01);
    check("ra_rdata", rdata, 32'h55AA_55AA);
    req = 2'b00;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
